rr_decode_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Each grant is a registered 3-bit index plus its one-hot 8-bit decode: index 0 -> 8'b0000_0001, index 7 -> 8'b1000_0000.
- Sits in front of any shared datapath slot that is selected by a 3-to-8 one-hot select.
- Bounds ownership with a hold-timeout so no requester can starve the others.

---
 rtl/rr_decode_arbiter8.sv | 122 ++++++++++++
 tb/tb_rr_decode_arbiter8.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant,
// its 3-bit index, and a hold-timeout that forcibly revokes long grants.
module rr_decode_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             timeout_q, timeout_d;

  logic [2:0] winner;
  logic [2:0] cand;
  logic       found;
  logic       req_any;
  logic       release_c;
  logic       expire_c;

  assign req_any   = |req;
  assign release_c = done | ~req[idx_q];
  assign expire_c  = (cnt_q == HOLD_LAST);

  // First set request at or above ptr, wrapping 7 -> 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register plus the datapath registers that travel with it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: a release has priority over expiry, both return to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_any) state_d = GRANT;
      GRANT:   if (release_c || expire_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          idx_d = winner;
          gnt_d = 8'b1 << winner;
          cnt_d = '0;
        end
      end
      GRANT: begin
        if (release_c || expire_c) begin
          gnt_d     = '0;
          ptr_d     = idx_q + 3'd1;
          timeout_d = ~release_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter8.sv
// Bench for rr_decode_arbiter8: expected grant indices are queued as stimulus
// is applied and a monitor pops one per new grant; tasks check timing inline.
module tb_rr_decode_arbiter8;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];
  logic [2:0] exp_idx;
  logic       prev_valid = 1'b0;

  rr_decode_arbiter8 #(
    .MAX_HOLD(MAX_HOLD),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .done     (done),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Scoreboard side: every new grant must match the next queued index.
  always @(negedge clk) begin
    if (gnt_valid && !prev_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL grant_order: got idx %0d, expected no grant", gnt_idx);
      end else begin
        exp_idx = exp_q.pop_front();
        if (gnt_idx !== exp_idx) begin
          n_fail++;
          $display("FAIL grant_order: got idx %0d, expected idx %0d", gnt_idx, exp_idx);
        end
      end
    end
    if (gnt_valid) begin
      n_tests++;
      if (gnt !== (8'b1 << gnt_idx)) begin
        n_fail++;
        $display("FAIL onehot: gnt %b with idx %0d", gnt, gnt_idx);
      end
    end else if (rst_n === 1'b1) begin
      n_tests++;
      if (gnt !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_zero: gnt %b while not valid", gnt);
      end
    end
    prev_valid = gnt_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: gnt %h valid %b timeout %b, expected 00 0 0", gnt, gnt_valid, timeout);
    end
    exp_q.push_back(3'd0);
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: gnt %h idx %0d, expected 01 0", gnt, gnt_idx);
    end
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 8'h20;
    exp_q.push_back(3'd5);
    tick();
    n_tests++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL single_grant: gnt %h idx %0d, expected 20 5", gnt, gnt_idx);
    end
    done = 1'b1;
    tick();
    n_tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: gnt %h valid %b, expected 00 0", gnt, gnt_valid);
    end
    done = 1'b0;
    exp_q.push_back(3'd5);
    tick();
    n_tests++;
    if (gnt !== 8'h20) begin
      n_fail++;
      $display("FAIL single_regrant: gnt %h, expected 20", gnt);
    end
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [7:0] want;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) exp_q.push_back(3'(k % 8));
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      want = 8'b1 << (k % 8);
      n_tests++;
      if (gnt !== want) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: gnt %h, expected %h", k, gnt, want);
      end
      if (k == 8) begin
        req  = 8'h00;
        done = 1'b0;
      end
      tick();
      n_tests++;
      if (gnt !== 8'h00) begin
        n_fail++;
        $display("FAIL rr_gap_%0d: gnt %h, expected 00", k, gnt);
      end
    end
  endtask

  task automatic test_pointer_skip();
    req = 8'h40;
    exp_q.push_back(3'd6);
    tick();
    n_tests++;
    if (gnt_idx !== 3'd6 || gnt_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL skip_setup: idx %0d valid %b, expected 6 1", gnt_idx, gnt_valid);
    end
    req  = 8'h09;
    done = 1'b1;
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd3);
    tick();
    tick();
    n_tests++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL skip_wrap: gnt %h idx %0d, expected 01 0", gnt, gnt_idx);
    end
    tick();
    tick();
    n_tests++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL skip_next: gnt %h idx %0d, expected 08 3", gnt, gnt_idx);
    end
    req = 8'h00;
    tick();
    done = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    req  = 8'h04;
    done = 1'b0;
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd2);
    for (int c = 0; c < MAX_HOLD; c++) begin
      tick();
      n_tests++;
      if (gnt !== 8'h04 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle_%0d: gnt %h timeout %b, expected 04 0", c, gnt, timeout);
      end
    end
    tick();
    n_tests++;
    if (gnt !== 8'h00 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_pulse: gnt %h timeout %b, expected 00 1", gnt, timeout);
    end
    tick();
    n_tests++;
    if (gnt !== 8'h04 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_regrant: gnt %h timeout %b, expected 04 0", gnt, timeout);
    end
    repeat (MAX_HOLD - 1) tick();
    done = 1'b1;
    req  = 8'h00;
    tick();
    n_tests++;
    if (gnt !== 8'h00 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL done_vs_timeout: gnt %h timeout %b, expected 00 0", gnt, timeout);
    end
    done = 1'b0;
    tick();
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_single_cycle: timeout %b, expected 0", timeout);
    end
  endtask

  task automatic test_async_reset();
    req = 8'h80;
    exp_q.push_back(3'd7);
    tick();
    n_tests++;
    if (gnt !== 8'h80) begin
      n_fail++;
      $display("FAIL async_setup: gnt %h, expected 80", gnt);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_clear: gnt %h valid %b, expected 00 0", gnt, gnt_valid);
    end
    req = 8'h81;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(3'd0);
    tick();
    n_tests++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_ptr: gnt %h idx %0d, expected 01 0", gnt, gnt_idx);
    end
    req  = 8'h00;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_timeout();
    test_async_reset();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_grants: %0d expected grants never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
